// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between the core and a simple memory bus.
// Accepts one load or store at a time, checks legality and alignment, issues a
// word-aligned bus request with byte strobes, waits for the response (bounded
// by TIMEOUT_CYC), then reports a one-cycle completion with extended load data.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid / in_ready              core operation handshake
//   readMemEnable / writeMemEnable   operation direction (exactly one must be set)
//   memOP, addr, wdata               funct3 width/sign, byte address, store data
//   out_valid, out_rdata, out_err    completion pulse, load result, error flag
//   mem_req_*                        bus request channel (valid/ready handshake)
//   mem_resp_valid, mem_resp_rdata   bus response (read data or write ack)
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        readMemEnable,
  input  logic        writeMemEnable,
  input  logic [2:0]  memOP,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        out_err_q, out_err_d;
  logic        req_valid_q, req_valid_d;
  logic        req_wen_q, req_wen_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_wmask_q, req_wmask_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic        load_q, load_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        one_dir_c;
  logic        legal_c;
  logic        misalign_c;
  logic [3:0]  st_mask_c;
  logic [31:0] st_wdata_c;
  logic [7:0]  ld_byte_c;
  logic [15:0] ld_half_c;
  logic [31:0] ld_data_c;

  // Incoming operation decode: direction, legality, alignment
  always_comb begin
    one_dir_c = readMemEnable ^ writeMemEnable;
    legal_c   = 1'b0;
    if (readMemEnable) begin
      case (memOP)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_c = 1'b1;
        default:                                legal_c = 1'b0;
      endcase
    end else begin
      case (memOP)
        3'b000, 3'b001, 3'b010: legal_c = 1'b1;
        default:                legal_c = 1'b0;
      endcase
    end
    misalign_c = ((memOP[1:0] == 2'b01) && addr[0]) ||
                 ((memOP[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // Store lane placement: data replicated, strobes select the addressed bytes
  always_comb begin
    case (memOP[1:0])
      2'b00: begin
        st_mask_c  = 4'b0001 << addr[1:0];
        st_wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        st_mask_c  = 4'b0011 << addr[1:0];
        st_wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        st_mask_c  = 4'b1111;
        st_wdata_c = wdata;
      end
    endcase
  end

  // Load extraction from the response word using the latched offset and op
  always_comb begin
    ld_byte_c = mem_resp_rdata[{off_q, 3'b000} +: 8];
    ld_half_c = mem_resp_rdata[{off_q[1], 4'b0000} +: 16];
    case (op_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b010:  ld_data_c = mem_resp_rdata;
      3'b100:  ld_data_c = {24'd0, ld_byte_c};
      3'b101:  ld_data_c = {16'd0, ld_half_c};
      default: ld_data_c = 32'd0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;
    req_wen_d   = req_wen_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wmask_d = req_wmask_q;
    op_d        = op_q;
    off_d       = off_q;
    load_d      = load_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid && one_dir_c) begin
          op_d   = memOP;
          off_d  = addr[1:0];
          load_d = readMemEnable;
          if (!legal_c || misalign_c) begin
            // Bad operations complete immediately without touching the bus
            state_d     = DONE;
            out_err_d   = 1'b1;
            out_rdata_d = 32'd0;
          end else begin
            state_d     = REQ;
            req_wen_d   = writeMemEnable;
            req_addr_d  = {addr[31:2], 2'b00};
            req_wdata_d = writeMemEnable ? st_wdata_c : 32'd0;
            req_wmask_d = writeMemEnable ? st_mask_c : 4'b0000;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_resp_valid) begin
          state_d     = DONE;
          out_err_d   = 1'b0;
          out_rdata_d = load_q ? ld_data_c : 32'd0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Last permitted WAIT cycle passed with no response
          state_d     = DONE;
          out_err_d   = 1'b1;
          out_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    req_valid_d = (state_d == REQ);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_rdata_q <= 32'd0;
      out_err_q   <= 1'b0;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= 32'd0;
      req_wdata_q <= 32'd0;
      req_wmask_q <= 4'b0000;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      load_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
      req_valid_q <= req_valid_d;
      req_wen_q   <= req_wen_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wmask_q <= req_wmask_d;
      op_q        <= op_d;
      off_q       <= off_d;
      load_q      <= load_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_rdata     = out_rdata_q;
  assign out_err       = out_err_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl (directed table, hand sequences,
// randomized operations against a transaction-level reference model).
module tb_lsu_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        readMemEnable;
  logic        writeMemEnable;
  logic [2:0]  memOP;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  lsu_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .readMemEnable  (readMemEnable),
    .writeMemEnable (writeMemEnable),
    .memOP          (memOP),
    .addr           (addr),
    .wdata          (wdata),
    .out_valid      (out_valid),
    .out_rdata      (out_rdata),
    .out_err        (out_err),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference model: expected bus fields and result of one operation
  function automatic void model(input logic rd, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rdat,
                                output logic skip, output logic [31:0] exp_rd,
                                output logic [3:0] exp_mask, output logic [31:0] exp_wd);
    int unsigned nb;
    int unsigned off;
    logic legal;
    logic [31:0] v;
    logic [31:0] lim;
    if (rd) legal = (op == 0) || (op == 1) || (op == 2) || (op == 4) || (op == 5);
    else    legal = (op == 0) || (op == 1) || (op == 2);
    nb  = 1 << op[1:0];
    off = a % 4;
    skip = !legal || ((a % nb) != 0);
    exp_mask = rd ? 4'b0000 : 4'(((1 << nb) - 1) << off);
    if (nb == 1)      exp_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
    else if (nb == 2) exp_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
    else              exp_wd = wd;
    v = rdat >> (8 * off);
    if (nb < 4) begin
      lim = (32'd1 << (8 * nb)) - 32'd1;
      v = v & lim;
      if (!op[2] && v[8*nb-1]) v = v | ~lim;
    end
    exp_rd = (rd && !skip) ? v : 32'd0;
  endfunction

  // Drive one operation end to end and check every cycle of it
  task automatic do_op(input logic rd, input logic wr, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                       input int rdy_dly, input int resp_dly, input logic noise,
                       input logic exp_skip, input logic [31:0] exp_rd,
                       input logic [3:0] exp_mask, input logic [31:0] exp_wd,
                       input string nm);
    logic to;
    logic [31:0] want_rd;
    chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; readMemEnable = rd; writeMemEnable = wr;
    memOP = op; addr = a; wdata = wd;
    step();
    in_valid = 1'b0; readMemEnable = 1'b0; writeMemEnable = 1'b0;
    memOP = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (exp_skip) begin
      chk({nm, ".skip_req_valid"}, 32'(mem_req_valid), 32'd0);
      chk({nm, ".skip_out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".skip_out_err"}, 32'(out_err), 32'd1);
      chk({nm, ".skip_out_rdata"}, out_rdata, 32'd0);
      step();
      chk({nm, ".skip_pulse_end"}, 32'(out_valid), 32'd0);
      chk({nm, ".skip_in_ready"}, 32'(in_ready), 32'd1);
      chk({nm, ".skip_req_valid2"}, 32'(mem_req_valid), 32'd0);
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      chk({nm, ".req_valid"}, 32'(mem_req_valid), 32'd1);
      chk({nm, ".req_addr"}, mem_req_addr, {a[31:2], 2'b00});
      chk({nm, ".req_wen"}, 32'(mem_req_wen), 32'(wr));
      chk({nm, ".req_wmask"}, 32'(mem_req_wmask), 32'(exp_mask));
      if (wr) chk({nm, ".req_wdata"}, mem_req_wdata, exp_wd);
      chk({nm, ".req_in_ready"}, 32'(in_ready), 32'd0);
      chk({nm, ".req_out_valid"}, 32'(out_valid), 32'd0);
      mem_req_ready  = (i == rdy_dly);
      mem_resp_valid = noise & 1'($urandom);
      mem_resp_rdata = $urandom;
      step();
    end
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    to = (resp_dly >= TO);
    for (int w = 0; w < TO; w++) begin
      chk({nm, ".wait_req_valid"}, 32'(mem_req_valid), 32'd0);
      chk({nm, ".wait_out_valid"}, 32'(out_valid), 32'd0);
      if (w == resp_dly) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = rdat;
      end
      step();
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      if (w == resp_dly) break;
    end
    want_rd = to ? 32'd0 : exp_rd;
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".out_err"}, 32'(out_err), 32'(to));
    chk({nm, ".out_rdata"}, out_rdata, want_rd);
    step();
    chk({nm, ".pulse_end"}, 32'(out_valid), 32'd0);
    chk({nm, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({nm, ".rdata_hold"}, out_rdata, want_rd);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdat;
    logic        skip;
    logic [31:0] exp_rd;
    logic [3:0]  mask;
    logic [31:0] exp_wd;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  initial begin
    logic        rd, skip;
    logic [2:0]  op;
    logic [31:0] a, wd, rdat, exp_rd, exp_wd;
    logic [3:0]  mask;

    tbl[0]  = '{1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 1'b0, 32'hFFFF_FF80, 4'b0000, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h1234_5678, 32'h0, 1'b0, 32'h0, 4'b1100, 32'h5678_5678};
    tbl[2]  = '{1'b1, 1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h1234_F600, 1'b0, 32'h0000_00F6, 4'b0000, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h9ABC_0000, 1'b0, 32'hFFFF_9ABC, 4'b0000, 32'h0};
    tbl[5]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0012, 32'h0, 32'hBEEF_0000, 1'b0, 32'h0000_BEEF, 4'b0000, 32'h0};
    tbl[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0007, 32'hAABB_CCDD, 32'h0, 1'b0, 32'h0, 4'b1000, 32'hDDDD_DDDD};
    tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D};
    tbl[8]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[10] = '{1'b0, 1'b1, 3'b001, 32'h0000_0003, 32'h2222_2222, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 1'b0, 32'h1357_9BDF, 4'b0000, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h7FFF_1234, 1'b0, 32'h0000_7FFF, 4'b0000, 32'h0};

    rst = 1'b1; in_valid = 1'b0; readMemEnable = 1'b0; writeMemEnable = 1'b0;
    memOP = 3'd0; addr = 32'd0; wdata = 32'd0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    step();
    step();
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_err", 32'(out_err), 32'd0);
    chk("rst.out_rdata", out_rdata, 32'd0);
    chk("rst.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst.req_wmask", 32'(mem_req_wmask), 32'd0);
    rst = 1'b0;
    step();

    // Directed table, minimum-latency handshake
    for (int i = 0; i < NV; i++)
      do_op(tbl[i].rd, tbl[i].wr, tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].rdat,
            0, 0, 1'b0, tbl[i].skip, tbl[i].exp_rd, tbl[i].mask, tbl[i].exp_wd,
            $sformatf("vec%0d", i));

    // Bus stall: request must stay put for all six REQ cycles; addr[1]=0 picks low half
    do_op(1'b1, 1'b0, 3'b101, 32'h0000_0010, 32'h0, 32'hBEEF_0000, 5, 0, 1'b1,
          1'b0, 32'h0000_0000, 4'b0000, 32'h0, "stall");

    // Timeout after TO silent WAIT cycles, then a normal op
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, TO + 3, 1'b0,
          1'b0, 32'h0, 4'b0000, 32'h0, "timeout");
    do_op(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 1, 2, 1'b0,
          1'b0, 32'h0, 4'b0010, 32'hA5A5_A5A5, "after_to");
    do_op(1'b1, 1'b0, 3'b000, 32'h0000_0002, 32'h0, 32'h00C3_0000, 0, TO - 1, 1'b0,
          1'b0, 32'hFFFF_FFC3, 4'b0000, 32'h0, "resp_last_wait");

    // Neither or both direction bits: ignored
    in_valid = 1'b1; readMemEnable = 1'b0; writeMemEnable = 1'b0; memOP = 3'b010; addr = 32'h40;
    step();
    readMemEnable = 1'b1; writeMemEnable = 1'b1;
    step();
    in_valid = 1'b0; readMemEnable = 1'b0; writeMemEnable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("ignore.in_ready", 32'(in_ready), 32'd1);
      chk("ignore.req_valid", 32'(mem_req_valid), 32'd0);
      chk("ignore.out_valid", 32'(out_valid), 32'd0);
      step();
    end

    // Stray responses while idle: no completion
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_BEEF;
    step();
    step();
    mem_resp_valid = 1'b0;
    chk("stray.out_valid", 32'(out_valid), 32'd0);
    chk("stray.in_ready", 32'(in_ready), 32'd1);

    // Load to leave non-reset outputs behind, then reset mid-WAIT
    do_op(1'b0, 1'b1, 3'b010, 32'h0000_0048, 32'h5555_AAAA, 32'h0, 0, 0, 1'b0,
          1'b0, 32'h0, 4'b1111, 32'h5555_AAAA, "pre_rst_st");
    do_op(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 0, 0, 1'b0,
          1'b0, 32'h1357_9BDF, 4'b0000, 32'h0, "pre_rst_ld");
    in_valid = 1'b1; writeMemEnable = 1'b1; memOP = 3'b010; addr = 32'h0000_0080; wdata = 32'h0F0F_0F0F;
    step();
    in_valid = 1'b0; writeMemEnable = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h2468_ACE0;
    step();
    mem_resp_valid = 1'b0;
    chk("rstw.out_valid", 32'(out_valid), 32'd0);
    chk("rstw.in_ready", 32'(in_ready), 32'd1);
    chk("rstw.out_err", 32'(out_err), 32'd0);
    chk("rstw.out_rdata", out_rdata, 32'd0);
    chk("rstw.req_valid", 32'(mem_req_valid), 32'd0);
    chk("rstw.req_wen", 32'(mem_req_wen), 32'd0);
    chk("rstw.req_addr", mem_req_addr, 32'd0);
    chk("rstw.req_wdata", mem_req_wdata, 32'd0);
    chk("rstw.req_wmask", 32'(mem_req_wmask), 32'd0);
    step();
    chk("rstw.out_valid2", 32'(out_valid), 32'd0);
    do_op(1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'h0, 32'hF100_0000, 0, 0, 1'b0,
          1'b0, 32'h0000_00F1, 4'b0000, 32'h0, "post_rst");

    // Randomized operations against the reference model
    for (int n = 0; n < 300; n++) begin
      rd = 1'($urandom);
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      if (op[1:0] == 2'b10 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if (op[1:0] == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      wd   = $urandom;
      rdat = $urandom;
      model(rd, op, a, wd, rdat, skip, exp_rd, mask, exp_wd);
      do_op(rd, !rd, op, a, wd, rdat, $urandom_range(0, 3), $urandom_range(0, TO + 1),
            1'b1, skip, exp_rd, mask, exp_wd, $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
